if_id_queue: RTL and testbench

Fetch-to-decode instruction queue placed directly downstream of the IF stage's PC register. Each cycle it accepts one fetched {PC, instruction} pair from IF and presents pairs in order to the ID stage. It decouples IF from ID stalls. Its `in_ready` output drives IF's `PCWrite`, so the PC advances only when the fetched pair is accepted. A `flush` input discards all queued pairs on a branch/jump redirect.

---
 rtl/if_id_queue_if.sv | 40 ++++
 rtl/if_id_queue.sv | 128 ++++++++++++
 tb/tb_if_id_queue.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/if_id_queue_if.sv
// ---------------------------------------------------------------------------
// if_id_queue_if
// Handshake bundle between the IF stage, the fetch-to-decode queue and the
// ID stage.
//
//   in_valid  : IF presents a fetched {pc, instr} pair
//   in_pc     : PC of the fetched instruction
//   in_instr  : instruction word read at in_pc
//   in_ready  : queue can take the pair (drives IF PCWrite)
//   out_valid : head pair valid for ID
//   out_pc    : head PC (0 when not valid)
//   out_instr : head instruction (0 / bubble when not valid)
//   out_ready : ID consumes the head this cycle
//
// Modports:
//   master : the IF/ID pipeline side (drives the fetch pair and out_ready)
//   slave  : the queue itself
// ---------------------------------------------------------------------------
interface if_id_queue_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic [W-1:0] in_pc;
  logic [W-1:0] in_instr;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_pc;
  logic [W-1:0] out_instr;
  logic         out_ready;

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
// Fetch-to-decode instruction queue sitting right after the IF PC register.
// Accepts one {PC, instruction} pair per cycle from IF and presents them in
// order to ID, decoupling IF from ID stalls. in_ready feeds IF PCWrite so the
// PC only advances once its fetched pair has been accepted. flush discards
// everything on a branch/jump redirect.
//
// Parameters:
//   DEPTH : number of entries (power of two, >= 2)
//   W     : width of the PC and instruction fields
//
// Ports:
//   clk   : single clock, all state changes on the rising edge
//   reset : synchronous active-high; empties the queue and zeroes storage
//   flush : redirect; empties the queue at the next edge
//   bus   : if_id_queue_if.slave handshake bundle (IF side and ID side)
//   count : number of stored entries, 0..DEPTH
//
// Build option:
//   IFQ_BYPASS_EN : when defined, an incoming pair falls through to the
//                   output in the same cycle while the queue is empty; if ID
//                   takes it in that cycle it is never written.
// ---------------------------------------------------------------------------
module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  if_id_queue_if.slave             bus,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Storage and pointers
  logic [W-1:0]  r_pc_mem    [DEPTH];
  logic [W-1:0]  r_instr_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_clear;
  logic w_bypass;
  logic w_bypass_take;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  // reset behaves as a flush for the datapath view of this cycle
  assign w_clear = flush | reset;

`ifdef IFQ_BYPASS_EN
  assign w_bypass = w_empty & bus.in_valid & ~w_clear;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed pair consumed by ID in the same cycle never touches storage.
  assign w_bypass_take = w_bypass & bus.out_ready;

  // in_ready depends on registered count only: no out_ready -> in_ready path,
  // so a full queue refuses a push even when ID pops in the same cycle.
  assign w_push = bus.in_valid & ~w_full & ~w_bypass_take;
  assign w_pop  = ~w_empty & bus.out_ready;

  // Control state: pointers and occupancy
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + AW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage: only reset wipes contents; flush just abandons them
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]    <= '0;
        r_instr_mem[i] <= '0;
      end
    end else if (w_push && !flush) begin
      r_pc_mem[r_wp]    <= bus.in_pc;
      r_instr_mem[r_wp] <= bus.in_instr;
    end
  end

  // Output side: head entry, fall-through pair, or a zero bubble
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_pc    = '0;
    bus.out_instr = '0;
    if (w_bypass) begin
      bus.out_valid = 1'b1;
      bus.out_pc    = bus.in_pc;
      bus.out_instr = bus.in_instr;
    end else if (!w_empty && !w_clear) begin
      bus.out_valid = 1'b1;
      bus.out_pc    = r_pc_mem[r_rp];
      bus.out_instr = r_instr_mem[r_rp];
    end
  end

  // In a flush cycle in_ready still shows the pre-flush occupancy.
  assign bus.in_ready = ~w_full;
  assign count        = r_count;

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;
  localparam int DEPTH = 4;
  localparam int W     = 32;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic [$clog2(DEPTH):0] count;

  if_id_queue_if #(.W(W)) bus ();

  if_id_queue #(.DEPTH(DEPTH), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // scoreboard of {pc, instr} pairs the queue must eventually deliver
  logic [63:0] sbq[$];
  int mcount = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {~pc[15:0], 16'h0013};
  endfunction

  // One cycle: drive inputs just after an edge, check mid-cycle against the
  // model, update scoreboard, then advance past the next edge.
  task automatic cyc(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                     input logic fl, input logic ordy, output logic acc);
    logic        exp_valid;
    logic [63:0] head;
    bus.in_valid  = iv;
    bus.in_pc     = pc;
    bus.in_instr  = ins;
    bus.out_ready = ordy;
    flush         = fl;
    #2;
    exp_valid = !fl && ((mcount != 0) || (BYP && iv));
    chk("in_ready", {31'b0, bus.in_ready}, {31'b0, (mcount != DEPTH)});
    chk("count", 32'(count), 32'(mcount));
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_valid});
    acc = iv && (mcount != DEPTH) && !fl;
    if (acc) sbq.push_back({pc, ins});
    if (exp_valid) begin
      head = sbq[0];
      chk("out_pc", bus.out_pc, head[63:32]);
      chk("out_instr", bus.out_instr, head[31:0]);
      if (ordy) void'(sbq.pop_front());
    end else begin
      chk("bubble_pc", bus.out_pc, 32'h0);
      chk("bubble_instr", bus.out_instr, 32'h0);
    end
    if (fl) sbq.delete();
    mcount = sbq.size();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        acc;
    logic [31:0] pc;
    bit          ok;

    // reset held with traffic on both sides
    reset = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b1; bus.in_pc = 32'h44; bus.in_instr = 32'h13; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_out_instr", bus.out_instr, 32'h0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
    reset = 1'b0; bus.in_valid = 1'b0;
    @(posedge clk); #1;

    // fill to full, fifth push refused
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'(i * 4), instr_of(32'(i * 4)), 1'b0, 1'b0, acc);
    chk("full_count", 32'(count), 32'(DEPTH));
    chk("full_in_ready", {31'b0, bus.in_ready}, 32'h0);
    cyc(1'b1, 32'h10, instr_of(32'h10), 1'b0, 1'b0, acc);
    chk("fifth_refused", {31'b0, acc}, 32'h0);

    // drain from full while IF keeps pushing; PC advances only on accept
    pc = 32'h10;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, pc, instr_of(pc), 1'b0, 1'b1, acc);
      if (i == 0) chk("no_push_on_full_pop", {31'b0, acc}, 32'h0);
      if (i == 1) chk("push_after_pop", {31'b0, acc}, 32'h1);
      if (acc) pc += 4;
    end
    ok = 0;
    for (int i = 0; i < 8; i++) begin
      if (mcount == 0) begin ok = 1; break; end
      cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
    end
    chk("drain1_done", {31'b0, ok}, 32'h1);

    // streaming with ID always ready
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 32'(i * 4), instr_of(32'(i * 4)), 1'b0, 1'b1, acc);
      chk("stream_count_le1", {31'b0, (count <= 1)}, 32'h1);
      if (BYP) chk("stream_count_byp0", 32'(count), 32'h0);
    end
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
    chk("stream_empty", 32'(count), 32'h0);

    // flush with simultaneous push and pop at count=3
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h200 + 32'(i * 4), instr_of(32'h200 + 32'(i * 4)), 1'b0, 1'b0, acc);
    chk("preflush_count", 32'(count), 32'h3);
    cyc(1'b1, 32'h20, instr_of(32'h20), 1'b1, 1'b1, acc);
    chk("postflush_count", 32'(count), 32'h0);
    chk("postflush_valid", {31'b0, bus.out_valid}, 32'h0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
    cyc(1'b1, 32'h100, instr_of(32'h100), 1'b0, 1'b0, acc);
    chk("redirect_pc", bus.out_pc, 32'h100);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);

    // empty queue, push with ID ready: same-cycle in bypass build
    cyc(1'b1, 32'h40, 32'h00000013, 1'b0, 1'b1, acc);
    chk("p40_count", 32'(count), BYP ? 32'h0 : 32'h1);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
    chk("p40_drained", 32'(count), 32'h0);

    // reset mid-operation overrides traffic and flush
    for (int i = 0; i < 2; i++) cyc(1'b1, 32'h300 + 32'(i * 4), instr_of(32'h300 + 32'(i * 4)), 1'b0, 1'b0, acc);
    reset = 1'b1; flush = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("midrst_count", 32'(count), 32'h0);
    chk("midrst_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("midrst_ready", {31'b0, bus.in_ready}, 32'h1);
    reset = 1'b0; flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    sbq.delete(); mcount = 0;
    @(posedge clk); #1;
    cyc(1'b1, 32'h500, instr_of(32'h500), 1'b0, 1'b0, acc);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
    chk("final_empty", 32'(count), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
